pwm_capture: RTL and testbench

//   Measures an incoming PWM waveform: period and high time in clk_in cycles,

---
 rtl/pwm_cap_pkg.sv | 20 ++
 rtl/pwm_sync_edge.sv | 45 ++++
 rtl/pwm_capture.sv | 184 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cap_pkg
//   Shared types and default constants for the PWM capture block.
//   cap_state_t  : measurement FSM states (IDLE, HIGH, LOW)
//   CAP_CNT_W    : default width of the cycle counter and of the results
//   CAP_TIMEOUT  : default number of edge-free cycles before the input is
//                  declared static (one second at 100 MHz)
// ---------------------------------------------------------------------------
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    localparam int unsigned CAP_CNT_W   = 32;
    localparam int unsigned CAP_TIMEOUT = 100_000_000;

endpackage

// File: rtl/pwm_sync_edge.sv
// ---------------------------------------------------------------------------
// pwm_sync_edge
//   Brings an asynchronous pin into the clock domain through two flops and
//   produces single-cycle rise/fall pulses from the synchronized level.
//   Generic enough to be reused for any slow asynchronous pin.
//   Ports:
//     i_clk    : sampling clock
//     i_rst_n  : asynchronous active-low reset, clears all three flops
//     i_async  : asynchronous input pin
//     o_level  : synchronized level (second sync flop)
//     o_rise   : 1 for one cycle when o_level goes 0 -> 1
//     o_fall   : 1 for one cycle when o_level goes 1 -> 0
// ---------------------------------------------------------------------------
module pwm_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // r_meta may go metastable; r_sync is the first trustworthy copy and
    // r_prev holds it for one more cycle so edges can be seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming PWM waveform: period (rising -> rising) and high
//   time (rising -> falling) in clk_in cycles, reported once per complete
//   cycle. A static input (0 %, 100 % duty or dead line) is flagged after
//   TIMEOUT edge-free cycles.
//   Ports:
//     clk_in      : system clock
//     rst_n_raw   : asynchronous active-low reset, release synchronized here
//     enable      : 1 = measure; 0 = return to IDLE, counter cleared,
//                   results held
//     pwm_in      : asynchronous PWM input
//     period_o    : last measured period in cycles
//     duty_o      : last measured high time in cycles
//     meas_valid  : one-cycle pulse when period_o/duty_o update
//     timeout_o   : sticky static-input flag, cleared by the next result
//     level_o     : synchronized input level captured at the timeout
// ---------------------------------------------------------------------------
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int unsigned CNT_W   = CAP_CNT_W,
    parameter int unsigned TIMEOUT = CAP_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n_raw,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] duty_o,
    output logic             meas_valid,
    output logic             timeout_o,
    output logic             level_o
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    logic [1:0]       r_rstSync;
    logic             w_rstN;

    logic             w_level;
    logic             w_rise;
    logic             w_fall;

    cap_state_t       r_state;
    cap_state_t       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_cntInc;
    logic [CNT_W-1:0] r_hiLat;
    logic [CNT_W-1:0] w_hiLatNext;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_periodNext;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] w_dutyNext;
    logic             r_valid;
    logic             w_validNext;
    logic             r_timeout;
    logic             w_timeoutNext;
    logic             r_level;
    logic             w_levelNext;

    // Reset asserts immediately but is released only after two clean clock
    // edges, so no flop leaves reset on a partial cycle.
    always_ff @(posedge clk_in or negedge rst_n_raw) begin
        if (!rst_n_raw) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    pwm_sync_edge u_syncEdge (
        .i_clk   (clk_in),
        .i_rst_n (w_rstN),
        .i_async (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Counter sticks at its maximum instead of wrapping to a small value.
    assign w_cntInc = (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + LP_ONE;

    // State, counter and result registers.
    always_ff @(posedge clk_in or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hiLat   <= '0;
            r_period  <= '0;
            r_duty    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_hiLat   <= w_hiLatNext;
            r_period  <= w_periodNext;
            r_duty    <= w_dutyNext;
            r_valid   <= w_validNext;
            r_timeout <= w_timeoutNext;
            r_level   <= w_levelNext;
        end
    end

    // Next-state logic. A cycle is only reported once it has been seen from
    // one detected rise to the next, so IDLE waits for a rise before timing.
    // An edge arriving on the cycle the counter reaches TIMEOUT takes
    // priority over the timeout.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_hiLatNext   = r_hiLat;
        w_periodNext  = r_period;
        w_dutyNext    = r_duty;
        w_validNext   = 1'b0;
        w_timeoutNext = r_timeout;
        w_levelNext   = r_level;

        if (!enable) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_stateNext = HIGH;
                        w_cntNext   = LP_ONE;
                    end
                end
                HIGH: begin
                    if (w_rise) begin
                        w_cntNext = LP_ONE;
                    end else if (w_fall) begin
                        w_hiLatNext = r_cnt;
                        w_cntNext   = w_cntInc;
                        w_stateNext = LOW;
                    end else if (r_cnt == LP_TIMEOUT) begin
                        w_timeoutNext = 1'b1;
                        w_levelNext   = w_level;
                        w_stateNext   = IDLE;
                        w_cntNext     = '0;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_periodNext  = r_cnt;
                        w_dutyNext    = r_hiLat;
                        w_validNext   = 1'b1;
                        w_timeoutNext = 1'b0;
                        w_cntNext     = LP_ONE;
                        w_stateNext   = HIGH;
                    end else if (!w_fall && (r_cnt == LP_TIMEOUT)) begin
                        w_timeoutNext = 1'b1;
                        w_levelNext   = w_level;
                        w_stateNext   = IDLE;
                        w_cntNext     = '0;
                    end else begin
                        w_cntNext = w_cntInc;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    assign period_o   = r_period;
    assign duty_o     = r_duty;
    assign meas_valid = r_valid;
    assign timeout_o  = r_timeout;
    assign level_o    = r_level;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//   Self-checking bench for pwm_capture (CNT_W=32, TIMEOUT=1000). A
//   timestamp-based reference model tracks the synchronized pin and the time
//   of the last counted rise, and predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int TB_CNT_W   = 32;
    localparam int TB_TIMEOUT = 1000;

    logic                clk_in;
    logic                rst_n_raw;
    logic                enable;
    logic                pwm_in;
    logic [TB_CNT_W-1:0] period_o;
    logic [TB_CNT_W-1:0] duty_o;
    logic                meas_valid;
    logic                timeout_o;
    logic                level_o;

    int vectors;
    int miscompares;

    pwm_capture #(
        .CNT_W   (TB_CNT_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_raw  (rst_n_raw),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_o   (period_o),
        .duty_o     (duty_o),
        .meas_valid (meas_valid),
        .timeout_o  (timeout_o),
        .level_o    (level_o)
    );

    // 100 MHz clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: synchronized pin history, time of last counted
    // rise, whether the high phase has ended, and predicted outputs.
    longint      cyc;
    longint      mTRise;
    longint      el;
    bit          mActive;
    bit          mHaveFall;
    logic [31:0] mHi;
    logic [31:0] mPeriod;
    logic [31:0] mDuty;
    logic        mValid;
    logic        mTimeout;
    logic        mLevel;
    logic        h1, h2, h3;
    logic        ms, mPrev;

    // The pin seen at edge k reaches the synchronized level two edges later,
    // so the cycle ending at edge k sees level p[k-2] with previous p[k-3].
    // Elapsed time since the last counted rise equals the DUT's count.
    always @(posedge clk_in) begin
        cyc++;
        if (!rst_n_raw) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            mActive = 1'b0; mHaveFall = 1'b0; mTRise = 0;
            mHi = '0; mPeriod = '0; mDuty = '0;
            mValid = 1'b0; mTimeout = 1'b0; mLevel = 1'b0;
        end else begin
            ms    = h2;
            mPrev = h3;
            h3 = h2; h2 = h1; h1 = pwm_in;
            mValid = 1'b0;
            el = cyc - mTRise;
            if (!enable) begin
                mActive = 1'b0;
            end else if (ms && !mPrev) begin
                if (mActive && mHaveFall) begin
                    mPeriod  = 32'(el);
                    mDuty    = mHi;
                    mValid   = 1'b1;
                    mTimeout = 1'b0;
                end
                mActive   = 1'b1;
                mHaveFall = 1'b0;
                mTRise    = cyc;
            end else if (mActive) begin
                if (!ms && mPrev && !mHaveFall) begin
                    mHi       = 32'(el);
                    mHaveFall = 1'b1;
                end else if (el == TB_TIMEOUT && !(!ms && mPrev)) begin
                    mTimeout = 1'b1;
                    mLevel   = ms;
                    mActive  = 1'b0;
                end
            end
        end
        #1;
        checkOutput("period", period_o, mPeriod);
        checkOutput("duty", duty_o, mDuty);
        checkOutput("valid", meas_valid, mValid);
        checkOutput("timeout", timeout_o, mTimeout);
        checkOutput("level", level_o, mLevel);
        if (meas_valid === 1'b1)
            checkOutput("dutyBelowPeriod", duty_o < period_o, 1);
    end

    // Drive n PWM periods, one pin value per clock.
    task automatic applyStimulus(input int high, input int period, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < period; j++) begin
                @(negedge clk_in);
                pwm_in = (j < high);
            end
        end
    endtask

    task automatic holdLevel(input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            pwm_in = v;
        end
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_n_raw = 1'b0;
        pwm_in    = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst period", period_o, 0);
        checkOutput("rst duty", duty_o, 0);
        checkOutput("rst valid", meas_valid, 0);
        checkOutput("rst timeout", timeout_o, 0);
        checkOutput("rst level", level_o, 0);
        rst_n_raw = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        int kind, per, hi, n;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n_raw   = 1'b1;
        enable      = 1'b1;
        pwm_in      = 1'b0;
        #2 rst_n_raw = 1'b0;
        doReset();

        // Basic measurement
        applyStimulus(25, 100, 3);
        checkOutput("t1 period", period_o, 100);
        checkOutput("t1 duty", duty_o, 25);
        checkOutput("t1 timeout", timeout_o, 0);

        // Static high, then static low after one rise
        holdLevel(1'b1, 1100);
        checkOutput("t2 timeout hi", timeout_o, 1);
        checkOutput("t2 level hi", level_o, 1);
        checkOutput("t2 period held", period_o, 100);
        checkOutput("t2 duty held", duty_o, 25);
        holdLevel(1'b0, 5);
        holdLevel(1'b1, 10);
        holdLevel(1'b0, 1100);
        checkOutput("t2 timeout lo", timeout_o, 1);
        checkOutput("t2 level lo", level_o, 0);

        // Recovery after timeout needs two rises
        applyStimulus(10, 40, 1);
        checkOutput("t3 still timed out", timeout_o, 1);
        applyStimulus(10, 40, 3);
        checkOutput("t3 period", period_o, 40);
        checkOutput("t3 duty", duty_o, 10);
        checkOutput("t3 timeout", timeout_o, 0);

        // Edges landing exactly on the timeout boundary
        applyStimulus(999, 1000, 3);
        checkOutput("t4 period", period_o, 1000);
        checkOutput("t4 duty", duty_o, 999);
        checkOutput("t4 timeout", timeout_o, 0);

        // Reset in the middle of a high phase
        holdLevel(1'b1, 20);
        doReset();
        applyStimulus(20, 60, 1);
        checkOutput("t5 no result yet", period_o, 0);
        applyStimulus(20, 60, 2);
        checkOutput("t5 period", period_o, 60);
        checkOutput("t5 duty", duty_o, 20);

        // Enable dropped in the low phase
        applyStimulus(15, 50, 2);
        holdLevel(1'b1, 15);
        holdLevel(1'b0, 10);
        @(negedge clk_in);
        enable = 1'b0;
        holdLevel(1'b0, 50);
        checkOutput("t6 period held", period_o, 50);
        checkOutput("t6 duty held", duty_o, 15);
        enable = 1'b1;
        applyStimulus(12, 45, 1);
        checkOutput("t6 first rise no result", period_o, 50);
        applyStimulus(12, 45, 2);
        checkOutput("t6 period", period_o, 45);
        checkOutput("t6 duty", duty_o, 12);

        // Randomized segments
        for (int seg = 0; seg < 25; seg++) begin
            kind = int'($urandom_range(0, 9));
            per  = int'($urandom_range(2, 300));
            hi   = int'($urandom_range(1, per - 1));
            n    = int'($urandom_range(1, 4));
            if (kind <= 6) begin
                applyStimulus(hi, per, n);
            end else if (kind == 7) begin
                holdLevel(1'($urandom_range(0, 1)), int'($urandom_range(50, 1200)));
            end else if (kind == 8) begin
                @(negedge clk_in);
                enable = 1'b0;
                applyStimulus(hi, per, 1);
                enable = 1'b1;
            end else begin
                doReset();
            end
        end

        repeat (5) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
